// File: rtl/pulse_decode.sv
// Decodes the number of X pulses between consecutive Y frame markers into a
// one-hot switch pattern, with frame length, last X pulse width and timeout.
module pulse_decode #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000,
  parameter logic [15:0] XW_MAX  = 16'hFFFF
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        Pulse_X,
  input  logic        Pulse_Y,
  output logic [3:0]  Enable_Det,
  output logic        Det_Valid,
  output logic        Det_Err,
  output logic        Timeout,
  output logic [23:0] Frame_Len,
  output logic [15:0] X_Width,
  output logic        o_dbg_state
);

  typedef enum logic [0:0] {IDLE = 1'b0, FRAME = 1'b1} state_t;

  state_t      r_state;
  logic        r_x_s1, r_x_s2, r_x_prev;
  logic        r_y_s1, r_y_s2, r_y_prev;
  logic [23:0] r_cnt;
  logic [2:0]  r_xcnt;
  logic [15:0] r_xhi;
  logic [15:0] r_xw;

  logic        w_x_rise, w_x_fall, w_y_rise;
  logic [23:0] w_cnt_inc;
  logic [3:0]  w_dec;
  logic        w_err;

  assign w_x_rise    = r_x_s2 & ~r_x_prev;
  assign w_x_fall    = ~r_x_s2 & r_x_prev;
  assign w_y_rise    = r_y_s2 & ~r_y_prev;
  assign w_cnt_inc   = r_cnt + 24'd1;
  assign o_dbg_state = r_state;

  always_comb begin
    w_dec = 4'b0000;
    w_err = 1'b0;
    case (r_xcnt)
      3'd1:    w_dec = 4'b0001;
      3'd2:    w_dec = 4'b0010;
      3'd3:    w_dec = 4'b0100;
      3'd4:    w_dec = 4'b1000;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_x_s1   <= 1'b0;
      r_x_s2   <= 1'b0;
      r_x_prev <= 1'b0;
      r_y_s1   <= 1'b0;
      r_y_s2   <= 1'b0;
      r_y_prev <= 1'b0;
    end else begin
      r_x_s1   <= Pulse_X;
      r_x_s2   <= r_x_s1;
      r_x_prev <= r_x_s2;
      r_y_s1   <= Pulse_Y;
      r_y_s2   <= r_y_s1;
      r_y_prev <= r_y_s2;
    end
  end

  // Runs in both states so a pulse spanning a frame boundary keeps its width.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_xhi <= 16'd0;
    end else if (w_x_rise) begin
      r_xhi <= 16'd1;
    end else if (r_x_s2 && (r_xhi != XW_MAX)) begin
      r_xhi <= r_xhi + 16'd1;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= 24'd0;
      r_xcnt     <= 3'd0;
      r_xw       <= 16'd0;
      Enable_Det <= 4'b0000;
      Det_Valid  <= 1'b0;
      Det_Err    <= 1'b0;
      Timeout    <= 1'b0;
      Frame_Len  <= 24'd0;
      X_Width    <= 16'd0;
    end else begin
      Det_Valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_y_rise) begin
            r_cnt   <= 24'd0;
            r_xcnt  <= {2'b00, w_x_rise};
            r_xw    <= 16'd0;
            r_state <= FRAME;
          end
        end
        FRAME: begin
          if (w_y_rise) begin
            // Close this frame and open the next on the same edge; a
            // coincident X edge belongs to the new frame.
            Det_Valid  <= 1'b1;
            Frame_Len  <= w_cnt_inc;
            X_Width    <= r_xw;
            Enable_Det <= w_dec;
            Det_Err    <= w_err;
            Timeout    <= 1'b0;
            r_cnt      <= 24'd0;
            r_xcnt     <= {2'b00, w_x_rise};
            r_xw       <= 16'd0;
          end else if (w_cnt_inc == TIMEOUT) begin
            Timeout    <= 1'b1;
            Enable_Det <= 4'b0000;
            r_state    <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_x_rise && (r_xcnt != 3'd7)) r_xcnt <= r_xcnt + 3'd1;
            if (w_x_fall) r_xw <= r_xhi;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_decode.sv
// Bench for pulse_decode: frames are built from a pulse plan; the expected
// decode of each frame is derived from that plan and checked on Det_Valid.
module tb_pulse_decode;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic        Pulse_X = 1'b0;
  logic        Pulse_Y = 1'b0;
  logic [3:0]  Enable_Det;
  logic        Det_Valid, Det_Err, Timeout, o_dbg_state;
  logic [23:0] Frame_Len;
  logic [15:0] X_Width;

  pulse_decode #(.TIMEOUT(24'd1000), .XW_MAX(16'hFFFF)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .Pulse_X     (Pulse_X),
    .Pulse_Y     (Pulse_Y),
    .Enable_Det  (Enable_Det),
    .Det_Valid   (Det_Valid),
    .Det_Err     (Det_Err),
    .Timeout     (Timeout),
    .Frame_Len   (Frame_Len),
    .X_Width     (X_Width),
    .o_dbg_state (o_dbg_state)
  );

  always #5 sysclk = ~sysclk;

  int errors = 0;
  int checks = 0;
  int dv_seen = 0;
  logic [44:0] exp_q[$];
  logic [44:0] last_e = '0;
  logic [44:0] pending = '0;
  bit          have_open = 1'b0;

  // Packed expectation: {Enable_Det, Det_Err, Frame_Len, X_Width}
  function automatic logic [44:0] expect_frame(input int n, input int len, input int xw);
    logic [3:0] en;
    logic       err;
    err = !(n >= 1 && n <= 4);
    en  = err ? 4'b0000 : (4'b0001 << (n - 1));
    return {en, err, 24'(len), 16'(xw)};
  endfunction

  always @(negedge sysclk) begin
    if (reset === 1'b1 && Det_Valid === 1'b1) begin
      logic [44:0] got;
      logic [44:0] e;
      dv_seen++;
      checks++;
      got = {Enable_Det, Det_Err, Frame_Len, X_Width};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_det_valid got=%h expected no strobe", got);
      end else begin
        e = exp_q.pop_front();
        last_e = e;
        if (got !== e) begin
          errors++;
          $display("FAIL frame_decode en=%b err=%b len=%0d xw=%0d required en=%b err=%b len=%0d xw=%0d",
                   got[44:41], got[40], got[39:16], got[15:0], e[44:41], e[40], e[39:16], e[15:0]);
        end
        checks++;
        if (Timeout !== 1'b0) begin
          errors++;
          $display("FAIL timeout_clear_on_close got=%b required=0", Timeout);
        end
      end
    end
  end

  task automatic step(input logic x, input logic y);
    Pulse_X = x;
    Pulse_Y = y;
    @(posedge sysclk);
    #1;
  endtask

  // One frame of len samples: Y marker at sample 0, then n X pulses of width w
  // (w == 0: random widths). x_with_y starts the first pulse on the Y sample.
  task automatic frame(input int len, input int n, input int w, input bit x_with_y);
    bit xs[$];
    int last_w;
    int wi;
    bit was_open;
    last_w = 0;
    if (!x_with_y) begin
      xs.push_back(1'b0);
      xs.push_back(1'b0);
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (int'($urandom_range(1, 4))) xs.push_back(1'b0);
      wi = (w > 0) ? w : int'($urandom_range(1, 12));
      repeat (wi) xs.push_back(1'b1);
      last_w = wi;
    end
    if (xs.size() > len - 1) begin
      errors++;
      $display("FAIL frame_layout pulses=%0d samples do not fit len=%0d", xs.size(), len);
    end
    while (xs.size() < len) xs.push_back(1'b0);
    was_open = have_open;
    if (have_open) exp_q.push_back(pending);
    pending   = expect_frame(n, len, (n > 0) ? last_w : 0);
    have_open = 1'b1;
    for (int t = 0; t < len; t++) begin
      step(xs[t], t == 0);
      if (t == 1) begin
        checks++;
        if (Det_Valid !== 1'b0) begin
          errors++;
          $display("FAIL strobe_too_early got=%b required=0", Det_Valid);
        end
      end
      if (t == 2) begin
        checks++;
        if (Det_Valid !== was_open) begin
          errors++;
          $display("FAIL strobe_latency got=%b required=%b", Det_Valid, was_open);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    checks++;
    if ({Enable_Det, Det_Valid, Det_Err, Timeout, Frame_Len, X_Width, o_dbg_state} !== 48'd0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b dv=%b err=%b to=%b len=%0d xw=%0d st=%b required all 0",
               Enable_Det, Det_Valid, Det_Err, Timeout, Frame_Len, X_Width, o_dbg_state);
    end
    reset = 1'b1;
    repeat (2) step(1'b0, 1'b0);
  endtask

  task automatic test_first_frame();
    repeat (6) step(1'b0, 1'b0);
    frame(200, 3, 5, 1'b0);
    checks++;
    if (dv_seen !== 0) begin
      errors++;
      $display("FAIL first_y_opens_only strobes=%0d required=0", dv_seen);
    end
    frame(100, 0, 0, 1'b0);
    frame(100, 0, 0, 1'b0);
  endtask

  task automatic test_error_counts();
    frame(100, 6, 0, 1'b0);
    frame(100, 1, 8, 1'b0);
    frame(100, 0, 0, 1'b0);
  endtask

  task automatic test_hold();
    frame(150, 2, 7, 1'b0);
    frame(150, 3, 0, 1'b0);
    checks++;
    if ({Enable_Det, Det_Err, Frame_Len, X_Width} !== last_e || Det_Valid !== 1'b0) begin
      errors++;
      $display("FAIL outputs_hold got=%h dv=%b required=%h dv=0",
               {Enable_Det, Det_Err, Frame_Len, X_Width}, Det_Valid, last_e);
    end
  endtask

  task automatic test_back_to_back();
    frame(100, 3, 4, 1'b0);
    frame(100, 2, 5, 1'b1);
    frame(100, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    frame(100, 2, 5, 1'b0);
    repeat (1200) step(1'b0, 1'b0);
    have_open = 1'b0;
    checks++;
    if (Timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set got=%b required=1", Timeout);
    end
    checks++;
    if (Enable_Det !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_enable_cleared got=%b required=0000", Enable_Det);
    end
    checks++;
    if (o_dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state_idle got=%b required=0", o_dbg_state);
    end
    frame(100, 2, 3, 1'b0);
    frame(100, 0, 0, 1'b0);
    checks++;
    if (Timeout !== 1'b0 || Enable_Det !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_recovery to=%b en=%b required to=0 en=0010", Timeout, Enable_Det);
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    frame(100, 3, 4, 1'b0);
    frame(60, 2, 6, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if ({Enable_Det, Det_Valid, Det_Err, Timeout, Frame_Len, X_Width, o_dbg_state} !== 48'd0) begin
      errors++;
      $display("FAIL reset_mid_frame got en=%b dv=%b err=%b to=%b len=%0d xw=%0d st=%b required all 0",
               Enable_Det, Det_Valid, Det_Err, Timeout, Frame_Len, X_Width, o_dbg_state);
    end
    have_open = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL strobes_before_reset pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) step(1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    seen = dv_seen;
    frame(100, 1, 3, 1'b0);
    checks++;
    if (dv_seen != seen) begin
      errors++;
      $display("FAIL reset_then_open_only strobes=%0d required=%0d", dv_seen, seen);
    end
    frame(100, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    repeat (15) begin
      frame(int'($urandom_range(100, 900)), int'($urandom_range(0, 6)), 0,
            bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_error_counts();
    test_hold();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    repeat (5) step(1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
